// File: rtl/spi_axi_regbank.sv
`default_nettype none
// ============================================================================
// Module   : spi_axi_regbank
// Purpose  : AXI4-Lite slave register bank. Each register is either writable
//            (byte-strobed storage) or read-only (value taken from hw_status).
//            AW and W are accepted independently and in either order.
// Ports    : S_AXI_*   - AXI4-Lite slave (clock, async active-low reset,
//                        AW/W/B/AR/R channels)
//            reg_q     - flat register contents, register i at [i*DW +: DW]
//            hw_status - read value for read-only registers
//            wr_pulse  - one-cycle strobe per committed register write
// Revision : 1.0 - initial release
// ============================================================================
module spi_axi_regbank #(
    parameter int                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                    C_S_AXI_ADDR_WIDTH = 6,
    parameter int                    C_NUM_REGS         = 4,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status,
    output logic [C_NUM_REGS-1:0]                    wr_pulse
);

    localparam int         DW       = C_S_AXI_DATA_WIDTH;
    localparam int         STRB_W   = DW / 8;
    localparam int         ADDR_LSB = $clog2(STRB_W);
    localparam int         IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b10;

    // Readies stay low until the first clock edge after reset release.
    logic              ready_en;
    logic              aw_held;
    logic              w_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DW-1:0]     wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [C_NUM_REGS-1:0] wr_ok_vec;
    logic              wr_ok;
    logic [DW-1:0]     rd_word;
    logic              rd_hit;
    logic [DW-1:0]     rd_view [C_NUM_REGS];

    assign S_AXI_AWREADY = ready_en && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = ready_en && !w_held && !S_AXI_BVALID;
    assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A held beat takes precedence: its partner is the one handshaking now.
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    // Out-of-range indices match no register, so they decode as an error.
    always_comb begin
        wr_ok_vec = '0;
        rd_word   = '0;
        rd_hit    = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (32'(wr_idx) == 32'(i)) begin
                wr_ok_vec[i] = !C_RO_MASK[i];
            end
            if (32'(rd_idx) == 32'(i)) begin
                rd_word = rd_view[i];
                rd_hit  = 1'b1;
            end
        end
    end
    assign wr_ok = |wr_ok_vec;

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        if (C_RO_MASK[i]) begin : g_ro
            assign reg_q[i*DW +: DW] = '0;
            assign rd_view[i]        = hw_status[i*DW +: DW];
        end else begin : g_rw
            logic [DW-1:0] value;
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    value <= '0;
                end else if (commit && wr_ok_vec[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            value[b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
            end
            assign reg_q[i*DW +: DW] = value;
            assign rd_view[i]        = value;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en     <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            wr_pulse     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
        end else begin
            ready_en <= 1'b1;

            if (commit)     aw_held <= 1'b0;
            else if (aw_hs) aw_held <= 1'b1;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

            if (commit)    w_held <= 1'b0;
            else if (w_hs) w_held <= 1'b1;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end

            wr_pulse <= commit ? wr_ok_vec : '0;

            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? RESP_OK : RESP_ERR;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            // rd_view holds pre-edge values, so a same-cycle write is not seen.
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_hit ? rd_word : '0;
                S_AXI_RRESP  <= rd_hit ? RESP_OK : RESP_ERR;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Protection bits, byte-offset bits and hw_status slices of writable
    // registers carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0],
                         hw_status};

endmodule
`default_nettype wire

// File: tb/tb_spi_axi_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_axi_regbank
// Purpose  : Self-checking bench for spi_axi_regbank. Three instances share
//            one stimulus bus selected by 'sel':
//              0 - defaults (32-bit, 4 regs, all writable)
//              1 - 32-bit, 4 regs, register 3 read-only
//              2 - 64-bit, 16 regs
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_axi_regbank;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  bq[$];
    logic [63:0] rq_data[$];
    logic [1:0]  rq_resp[$];

    always #5 clk = ~clk;

    // Per-instance outputs
    logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
    logic [1:0]   a_bresp, a_rresp;
    logic [31:0]  a_rdata;
    logic [127:0] a_reg_q;
    logic [3:0]   a_pulse;
    logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
    logic [1:0]   b_bresp, b_rresp;
    logic [31:0]  b_rdata;
    logic [127:0] b_reg_q;
    logic [3:0]   b_pulse;
    logic         c_awready, c_wready, c_bvalid, c_arready, c_rvalid;
    logic [1:0]   c_bresp, c_rresp;
    logic [63:0]  c_rdata;
    logic [1023:0] c_reg_q;
    logic [15:0]  c_pulse;

    logic [127:0] b_hw_status;
    assign b_hw_status = {32'hCAFE0001, 32'h11111111, 32'h22222222, 32'h33333333};

    spi_axi_regbank u_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr[5:0]), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid && sel == 0), .S_AXI_AWREADY(a_awready),
        .S_AXI_WDATA(wdata[31:0]), .S_AXI_WSTRB(wstrb[3:0]),
        .S_AXI_WVALID(wvalid && sel == 0), .S_AXI_WREADY(a_wready),
        .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr[5:0]), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid && sel == 0), .S_AXI_ARREADY(a_arready),
        .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid),
        .S_AXI_RREADY(rready), .reg_q(a_reg_q), .hw_status({4{32'h5A5A0000}}),
        .wr_pulse(a_pulse)
    );

    spi_axi_regbank #(.C_RO_MASK(4'b1000)) u_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr[5:0]), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid && sel == 1), .S_AXI_AWREADY(b_awready),
        .S_AXI_WDATA(wdata[31:0]), .S_AXI_WSTRB(wstrb[3:0]),
        .S_AXI_WVALID(wvalid && sel == 1), .S_AXI_WREADY(b_wready),
        .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr[5:0]), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid && sel == 1), .S_AXI_ARREADY(b_arready),
        .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid),
        .S_AXI_RREADY(rready), .reg_q(b_reg_q), .hw_status(b_hw_status),
        .wr_pulse(b_pulse)
    );

    spi_axi_regbank #(.C_S_AXI_DATA_WIDTH(64), .C_S_AXI_ADDR_WIDTH(7), .C_NUM_REGS(16)) u_c (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr[6:0]), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid && sel == 2), .S_AXI_AWREADY(c_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid && sel == 2), .S_AXI_WREADY(c_wready),
        .S_AXI_BRESP(c_bresp), .S_AXI_BVALID(c_bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr[6:0]), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid && sel == 2), .S_AXI_ARREADY(c_arready),
        .S_AXI_RDATA(c_rdata), .S_AXI_RRESP(c_rresp), .S_AXI_RVALID(c_rvalid),
        .S_AXI_RREADY(rready), .reg_q(c_reg_q), .hw_status('0),
        .wr_pulse(c_pulse)
    );

    // Selected-instance view
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    logic [15:0] wr_pulse;

    always_comb begin
        awready = a_awready; wready = a_wready; bvalid = a_bvalid; bresp = a_bresp;
        arready = a_arready; rvalid = a_rvalid; rresp = a_rresp;
        rdata = {32'h0, a_rdata}; wr_pulse = {12'h0, a_pulse};
        if (sel == 1) begin
            awready = b_awready; wready = b_wready; bvalid = b_bvalid; bresp = b_bresp;
            arready = b_arready; rvalid = b_rvalid; rresp = b_rresp;
            rdata = {32'h0, b_rdata}; wr_pulse = {12'h0, b_pulse};
        end else if (sel == 2) begin
            awready = c_awready; wready = c_wready; bvalid = c_bvalid; bresp = c_bresp;
            arready = c_arready; rvalid = c_rvalid; rresp = c_rresp;
            rdata = c_rdata; wr_pulse = c_pulse;
        end
    end

    // All transaction tasks start and end 1 time unit after a rising edge.
    task automatic axi_write(input logic [7:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] exp_resp,
                             input logic [15:0] exp_pulse, input string name);
        int cnt;
        logic [1:0] er;
        bq.push_back(exp_resp);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
        cnt = 0;
        while (!(awready && wready) && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        if (cnt >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL %s aw_w_timeout: readies %b%b required 11", name, awready, wready);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        er = bq.pop_front();
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== er) begin
            n_fail++;
            $display("FAIL %s bresp: bvalid=%b bresp=%b required bvalid=1 bresp=%b", name, bvalid, bresp, er);
        end
        n_tests++;
        if (wr_pulse !== exp_pulse) begin
            n_fail++;
            $display("FAIL %s wr_pulse: got %h required %h", name, wr_pulse, exp_pulse);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bvalid !== 1'b0 || wr_pulse !== 16'h0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s b_clear: bvalid=%b pulse=%h awready=%b wready=%b required 0 0000 1 1",
                     name, bvalid, wr_pulse, awready, wready);
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [63:0] exp_data,
                            input logic [1:0] exp_resp, input string name);
        int cnt;
        logic [63:0] ed;
        logic [1:0]  er;
        rq_data.push_back(exp_data);
        rq_resp.push_back(exp_resp);
        araddr = addr; arvalid = 1;
        cnt = 0;
        while (!arready && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        if (cnt >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL %s ar_timeout: arready %b required 1", name, arready);
        end
        @(posedge clk); #1;
        arvalid = 0;
        ed = rq_data.pop_front();
        er = rq_resp.pop_front();
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== ed || rresp !== er) begin
            n_fail++;
            $display("FAIL %s rdata: rvalid=%b rdata=%h rresp=%b required 1 %h %b",
                     name, rvalid, rdata, rresp, ed, er);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s r_clear: rvalid=%b arready=%b required 0 1", name, rvalid, arready);
        end
    endtask

    task automatic test_reset();
        #7;  // just after the first rising edge, reset still asserted
        n_tests++;
        if ({a_awready, a_wready, a_arready, a_bvalid, a_rvalid, c_awready, c_arready} !== 7'b0
            || a_reg_q !== '0 || b_reg_q !== '0 || c_reg_q !== '0) begin
            n_fail++;
            $display("FAIL reset_state: readies/valids=%b required 0000000 or reg_q nonzero",
                     {a_awready, a_wready, a_arready, a_bvalid, a_rvalid, c_awready, c_arready});
        end
        @(negedge clk); rst_n = 1; #1;
        n_tests++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: awready=%b arready=%b required 0 0", awready, arready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: %b%b%b required 111", awready, wready, arready);
        end
    endtask

    task automatic test_sequential(input int s, input int n, input int stride);
        logic [63:0] d;
        sel = s;
        for (int i = 0; i < n; i++) begin
            d = 64'(i + 1) | ((s == 2) ? (64'(i + 1) << 40) : 64'h0);
            axi_write(8'(i * stride), d, 8'hFF, OKAY, 16'(1 << i), "seq_write");
        end
        for (int i = 0; i < n; i++) begin
            d = 64'(i + 1) | ((s == 2) ? (64'(i + 1) << 40) : 64'h0);
            axi_read(8'(i * stride), d, OKAY, "seq_read");
        end
        n_tests++;
        if (s == 0 && a_reg_q !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
            n_fail++;
            $display("FAIL seq_reg_q: got %h required 00000004000000030000000200000001", a_reg_q);
        end else if (s == 2 && c_reg_q[15*64 +: 64] !== 64'h0000_1000_0000_0010) begin
            n_fail++;
            $display("FAIL seq_reg_q15: got %h required 0000100000000010", c_reg_q[15*64 +: 64]);
        end
    endtask

    task automatic test_strobes();
        sel = 0;
        axi_write(8'h00, 64'hAABBCCDD, 8'h0F, OKAY, 16'h1, "strb_full");
        axi_write(8'h00, 64'h11223344, 8'h05, OKAY, 16'h1, "strb_partial");
        axi_read(8'h00, 64'hAA22CC44, OKAY, "strb_read");
    endtask

    task automatic test_order();
        logic [1:0] er;
        sel = 0;
        wdata = 64'h55; wstrb = 8'h0F; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL order_hold: wready=%b bvalid=%b required 0 0", wready, bvalid);
            end
            @(posedge clk); #1;
        end
        bq.push_back(OKAY);
        awaddr = 8'h08; awvalid = 1;
        n_tests++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL order_awready: got %b required 1", awready);
        end
        @(posedge clk); #1;
        awvalid = 0;
        er = bq.pop_front();
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== er || wr_pulse !== 16'h4) begin
            n_fail++;
            $display("FAIL order_commit: bvalid=%b bresp=%b pulse=%h required 1 %b 0004",
                     bvalid, bresp, wr_pulse, er);
        end
        @(posedge clk); #1;
        axi_read(8'h08, 64'h55, OKAY, "order_read");
    endtask

    task automatic test_errors();
        sel = 1;
        axi_write(8'h0C, 64'h12345678, 8'h0F, SLVERR, 16'h0, "err_ro_write");
        n_tests++;
        if (b_reg_q[127:96] !== 32'h0) begin
            n_fail++;
            $display("FAIL err_ro_slice: got %h required 00000000", b_reg_q[127:96]);
        end
        axi_read(8'h0C, 64'hCAFE0001, OKAY, "err_ro_read");
        axi_read(8'h10, 64'h0, SLVERR, "err_oor_read");
        axi_write(8'h10, 64'h9, 8'h0F, SLVERR, 16'h0, "err_oor_write");
        axi_write(8'h04, 64'hBEEF, 8'h0F, OKAY, 16'h2, "err_rw_write");
        axi_read(8'h04, 64'hBEEF, OKAY, "err_rw_read");
    endtask

    task automatic test_backpressure();
        logic [1:0]  er;
        logic [63:0] ed;
        logic [1:0]  err_r;
        sel = 0;
        bready = 0; rready = 0;
        bq.push_back(OKAY);
        rq_data.push_back(64'h2);   // reg1 still holds its pre-write value
        rq_resp.push_back(OKAY);
        awaddr = 8'h04; wdata = 64'h77; wstrb = 8'h0F; araddr = 8'h04;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        er = bq.pop_front();
        ed = rq_data.pop_front();
        err_r = rq_resp.pop_front();
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== er || wr_pulse !== 16'h2 ||
            rvalid !== 1'b1 || rdata !== ed || rresp !== err_r) begin
            n_fail++;
            $display("FAIL bp_first: b=%b/%b pulse=%h r=%b/%h/%b required 1/%b 0002 1/%h/%b",
                     bvalid, bresp, wr_pulse, rvalid, rdata, rresp, er, ed, err_r);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bvalid !== 1'b1 || bresp !== er || rvalid !== 1'b1 || rdata !== ed ||
                rresp !== err_r || wr_pulse !== 16'h0 ||
                awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: b=%b/%b r=%b/%h pulse=%h rdy=%b%b%b required 1/%b 1/%h 0000 000",
                         bvalid, bresp, rvalid, rdata, wr_pulse, awready, wready, arready, er, ed);
            end
        end
        bready = 1; rready = 1;
        @(posedge clk); #1;
        n_tests++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: bvalid=%b rvalid=%b awready=%b arready=%b required 0 0 1 1",
                     bvalid, rvalid, awready, arready);
        end
        axi_read(8'h04, 64'h77, OKAY, "bp_readback");
    endtask

    task automatic test_reset_mid();
        logic [1:0] er;
        sel = 0;
        awaddr = 8'h08; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        n_tests++;
        if (awready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_aw_held: awready=%b required 0", awready);
        end
        #3 rst_n = 0;
        #1;
        n_tests++;
        if (a_reg_q !== '0 || awready !== 1'b0 || wready !== 1'b0 ||
            arready !== 1'b0 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: reg_q=%h rdy=%b%b%b bvalid=%b required 0 000 0",
                     a_reg_q, awready, wready, arready, bvalid);
        end
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1; #1;
        n_tests++;
        if (awready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_early: awready=%b required 0", awready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: %b%b%b required 111", awready, wready, arready);
        end
        // A lone W beat must not pair with the address captured before reset.
        wdata = 64'h99; wstrb = 8'h0F; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bvalid !== 1'b0 || a_reg_q !== '0) begin
                n_fail++;
                $display("FAIL rst_no_commit: bvalid=%b reg_q=%h required 0 0", bvalid, a_reg_q);
            end
            @(posedge clk); #1;
        end
        bq.push_back(OKAY);
        awaddr = 8'h00; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        er = bq.pop_front();
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== er || wr_pulse !== 16'h1) begin
            n_fail++;
            $display("FAIL rst_late_aw: bvalid=%b bresp=%b pulse=%h required 1 %b 0001",
                     bvalid, bresp, wr_pulse, er);
        end
        @(posedge clk); #1;
        axi_read(8'h00, 64'h99, OKAY, "rst_readback");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential(0, 4, 4);
        test_strobes();
        test_order();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_sequential(2, 16, 8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
